uart_cmd_wrapper: RTL and testbench

UART_CMD_WRAPPER -- requirements
Module: uart_cmd_wrapper

---
 rtl/uart_cmd_pkg.sv | 15 +
 rtl/uart_byte.sv | 139 +++++++++++++
 rtl/uart_cmd_wrapper.sv | 87 ++++++++
 tb/tb_uart_cmd_wrapper.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command wrapper.
package uart_cmd_pkg;

  // Command assembly: waiting for the high byte, then the low byte
  typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;

  // Serial receiver and transmitter activity
  typedef enum logic {RX_IDLE, RX_BUSY} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  // Canonical response bytes
  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] NEG_ACK = 8'h5A;

endpackage

// File: rtl/uart_byte.sv
// Full-duplex 8N1 byte receiver/transmitter. The receiver and the transmitter
// share only the clock and reset, so both directions run independently.
module uart_byte
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_vld,
  output logic       rx_start,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_done
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

  // ---------------- receiver ----------------
  logic            rx_s1, rx_s2, rx_prev;
  rx_state_t       rx_st, rx_nxt;
  logic [CW-1:0]   rx_cnt;
  logic [3:0]      rx_bit;
  logic [7:0]      rx_sh;
  logic            rx_fall, rx_samp;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall  = rx_prev & ~rx_s2;
  assign rx_samp  = (rx_st == RX_BUSY) && (rx_cnt == '0);
  assign rx_start = (rx_st == RX_IDLE) && rx_fall;
  assign rx_vld   = rx_samp && (rx_bit == 4'd9);
  assign rx_byte  = rx_sh;

  // Receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_st <= RX_IDLE;
    else        rx_st <= rx_nxt;
  end

  // Receiver next state: a high start sample is a false start
  always_comb begin
    rx_nxt = rx_st;
    case (rx_st)
      RX_IDLE: if (rx_fall) rx_nxt = RX_BUSY;
      RX_BUSY: if (rx_samp && ((rx_bit == 4'd0 && rx_s2) || rx_bit == 4'd9))
                 rx_nxt = RX_IDLE;
      default: rx_nxt = RX_IDLE;
    endcase
  end

  // Mid-bit sampling: first sample half a bit after the edge, then every bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else if (rx_start) begin
      rx_cnt <= HALF_M1;
      rx_bit <= '0;
    end else if (rx_st == RX_BUSY) begin
      if (rx_samp) begin
        rx_cnt <= FULL_M1;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit >= 4'd1 && rx_bit <= 4'd8) rx_sh <= {rx_s2, rx_sh[7:1]};
      end else begin
        rx_cnt <= rx_cnt - 1'b1;
      end
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t       tx_st, tx_nxt;
  logic [CW-1:0]   tx_cnt;
  logic [3:0]      tx_bit;
  logic [9:0]      tx_sh;
  logic            tx_go, tx_end;

  assign tx_go  = (tx_st == TX_IDLE) && trmt;
  assign tx_end = (tx_st == TX_BUSY) && (tx_cnt == '0) && (tx_bit == 4'd9);
  assign tx     = tx_sh[0];

  // Transmitter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_st <= TX_IDLE;
    else        tx_st <= tx_nxt;
  end

  // Transmitter next state: trmt is only honoured while idle
  always_comb begin
    tx_nxt = tx_st;
    case (tx_st)
      TX_IDLE: if (trmt)   tx_nxt = TX_BUSY;
      TX_BUSY: if (tx_end) tx_nxt = TX_IDLE;
      default: tx_nxt = TX_IDLE;
    endcase
  end

  // Frame shifter; ones fill behind so the line idles high after the stop bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '1;
      tx_done <= 1'b0;
    end else if (tx_go) begin
      tx_sh   <= {1'b1, tx_data, 1'b0};
      tx_cnt  <= FULL_M1;
      tx_bit  <= '0;
      tx_done <= 1'b0;
    end else if (tx_st == TX_BUSY) begin
      if (tx_cnt == '0) begin
        tx_sh  <= {1'b1, tx_sh[9:1]};
        tx_cnt <= FULL_M1;
        tx_bit <= tx_bit + 4'd1;
      end else begin
        tx_cnt <= tx_cnt - 1'b1;
      end
      if (tx_end) tx_done <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles two received bytes (high first) into a 16-bit command and sends
// single-byte responses. Define CMD_TIMEOUT_EN to abandon a half-received
// command after TIMEOUT_CYC idle cycles in WAIT_LO.
module uart_cmd_wrapper
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV    = 5208,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        trmt,
  input  logic [7:0]  resp,
  output logic        tx_done
);

  asm_state_t st, nxt;
  logic [7:0] rx_byte;
  logic       byte_vld, rx_start, timeout;

  uart_byte #(.BAUD_DIV(BAUD_DIV)) u_byte (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (RX),
    .rx_byte  (rx_byte),
    .rx_vld   (byte_vld),
    .rx_start (rx_start),
    .trmt     (trmt),
    .tx_data  (resp),
    .tx       (TX),
    .tx_done  (tx_done)
  );

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  // Idle-time counter, live only while a low byte is outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      to_cnt <= '0;
    else if (st != WAIT_LO || byte_vld) to_cnt <= '0;
    else                             to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (st == WAIT_LO) && !byte_vld && (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // Assembly state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= WAIT_HI;
    else        st <= nxt;
  end

  // Assembly next state; a timeout simply forgets the pending high byte
  always_comb begin
    nxt = st;
    case (st)
      WAIT_HI: if (byte_vld)            nxt = WAIT_LO;
      WAIT_LO: if (byte_vld || timeout) nxt = WAIT_HI;
      default: nxt = WAIT_HI;
    endcase
  end

  // Command register: high byte lands first, low byte completes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmd <= '0;
    else if (byte_vld) begin
      if (st == WAIT_HI) cmd[15:8] <= rx_byte;
      else               cmd[7:0]  <= rx_byte;
    end
  end

  // Ready flag: set beats clear; a new command's start bit also clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      cmd_rdy <= 1'b0;
    else if (byte_vld && st == WAIT_LO)              cmd_rdy <= 1'b1;
    else if (clr_cmd_rdy || (rx_start && st == WAIT_HI)) cmd_rdy <= 1'b0;
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Randomized self-checking bench for uart_cmd_wrapper with a byte-level model.
module tb_uart_cmd_wrapper;

  localparam int B  = 16;
  localparam int TO = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        trmt = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX, cmd_rdy, tx_done;
  logic [15:0] cmd;

  int n_vec = 0;
  int n_err = 0;

  // model of the command side: byte stream -> {hi, lo}
  logic [15:0] m_cmd = 16'h0000;
  logic        m_rdy = 1'b0;
  bit          m_lo_phase = 1'b0;
  logic        rdy_at_stop;

  always #5 clk = ~clk;

  uart_cmd_wrapper #(.BAUD_DIV(B), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .trmt(trmt), .resp(resp), .tx_done(tx_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (!m_lo_phase) begin
      m_cmd[15:8] = b;
      m_rdy = 1'b0;
      m_lo_phase = 1'b1;
    end else begin
      m_cmd[7:0] = b;
      m_rdy = 1'b1;
      m_lo_phase = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      for (int k = 0; k < B; k++) begin
        if (i == 9 && k == 2) rdy_at_stop = cmd_rdy;
        @(negedge clk);
      end
    end
  endtask

  task automatic send_cmd(input logic [7:0] hi, input logic [7:0] lo);
    send_byte(hi);
    model_byte(hi);
    chk("hi_cmd", cmd, m_cmd);
    chk("hi_rdy", cmd_rdy, m_rdy);
    send_byte(lo);
    chk("rdy_before_set", rdy_at_stop, 1'b0);
    model_byte(lo);
    chk("cmd", cmd, m_cmd);
    chk("cmd_rdy", cmd_rdy, m_rdy);
  endtask

  task automatic pulse_clr();
    @(negedge clk) clr_cmd_rdy = 1'b1;
    @(negedge clk) clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    chk("rdy_after_clr", cmd_rdy, m_rdy);
  endtask

  // Transmit r and compare every cycle of TX against the ideal 8N1 waveform
  task automatic send_resp(input logic [7:0] r, input bit mid_trmt);
    logic [9:0] fr;
    int bad;
    fr = {1'b1, r, 1'b0};
    bad = 0;
    @(negedge clk);
    resp = r;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    chk("tx_done_cleared", tx_done, 1'b0);
    for (int j = 0; j < 10 * B; j++) begin
      trmt = (mid_trmt && j == 5 * B);
      if (mid_trmt && j == 5 * B) resp = ~r;
      if (TX !== fr[j / B]) bad++;
      @(negedge clk);
    end
    chk("tx_wave_errs", bad, 0);
    chk("tx_idle", TX, 1'b1);
    chk("tx_done", tx_done, 1'b1);
  endtask

  // Raise clr_cmd_rdy exactly on the cycle the low byte completes
  task automatic clr_on_set();
    int seen;
    seen = 0;
    for (int k = 0; k < 25 * B && seen < 2; k++) begin
      @(negedge clk);
      if (dut.byte_vld) begin
        seen++;
        if (seen == 2) begin
          clr_cmd_rdy = 1'b1;
          @(negedge clk);
          clr_cmd_rdy = 1'b0;
        end
      end
    end
    chk("coincide_vld_seen", seen, 2);
  endtask

  initial begin
    logic [7:0] h, l, r;
    repeat (3) @(negedge clk);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_rdy", cmd_rdy, 1'b0);
    chk("rst_tx", TX, 1'b1);
    chk("rst_tx_done", tx_done, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send_cmd(8'h20, 8'h00);
    pulse_clr();
    send_cmd(8'h53, 8'h21);

    send_resp(8'hA5, 1'b1);

    // full duplex: command in and response out at the same time
    h = 8'($urandom); l = 8'($urandom); r = 8'($urandom);
    fork
      send_cmd(h, l);
      send_resp(r, 1'b0);
    join

    for (int i = 0; i < 5; i++) begin
      h = 8'($urandom); l = 8'($urandom);
      if ($urandom_range(1) == 1) pulse_clr();
      send_cmd(h, l);
      if ($urandom_range(1) == 1) send_resp(8'($urandom), 1'b0);
    end

    // clear and set in the same cycle: set wins
    fork
      send_cmd(8'hC3, 8'h3C);
      clr_on_set();
    join
    repeat (3) @(negedge clk);
    chk("rdy_hold_after_coincide", cmd_rdy, 1'b1);

    // reset with a byte arriving and a response in flight
    @(negedge clk);
    resp = 8'h00;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    RX = 1'b0;
    repeat (3 * B) @(negedge clk);
    chk("tx_busy_before_rst", TX, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("rst2_tx", TX, 1'b1);
    chk("rst2_cmd", cmd, 16'h0000);
    chk("rst2_rdy", cmd_rdy, 1'b0);
    RX = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_cmd = 16'h0000; m_rdy = 1'b0; m_lo_phase = 1'b0;
    repeat (2 * B) @(negedge clk);
    send_cmd(8'h12, 8'h34);
    chk("post_rst_cmd", cmd, 16'h1234);

`ifdef CMD_TIMEOUT_EN
    send_byte(8'hAB);
    chk("to_rdy_after_hi", cmd_rdy, 1'b0);
    repeat (TO + 4 * B) @(negedge clk);
    chk("to_rdy_idle", cmd_rdy, 1'b0);
    m_lo_phase = 1'b0; m_rdy = 1'b0; m_cmd[15:8] = 8'hAB;
    send_cmd(8'h20, 8'h00);
    chk("to_cmd", cmd, 16'h2000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
